// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/memory-stage port arbiter.
// Grant states and last-grant selector values.
package mem_port_arbiter_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GNT_IF = 2'd1;
  localparam logic [1:0] GNT_DM = 2'd2;

  localparam logic GNT_IF_SEL = 1'b0;
  localparam logic GNT_DM_SEL = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// Two-input word mux used for the shared memory address/data path.
// sel=0 picks a, sel=1 picks b.
module mux2 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and memory stages onto one wait-stated memory port.
// Round-robin between requesters, fixed WAIT_CYCLES extra cycles per access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic              if_elig, dm_elig, pick_dm;
  logic              gnt, sel_dm;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  // A requester being acked this cycle sits out, so the other one wins.
  assign if_elig = if_req && !if_ack_q;
  assign dm_elig = dm_req && !dm_ack_q;
  assign pick_dm = dm_elig && (!if_elig || last_gnt_q == GNT_IF_SEL);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_elig || dm_elig) begin
          state_d    = pick_dm ? GNT_DM : GNT_IF;
          cnt_d      = 4'(WAIT_CYCLES);
          last_gnt_d = pick_dm ? GNT_DM_SEL : GNT_IF_SEL;
        end
      end
      GNT_IF, GNT_DM: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          if (state_q == GNT_DM) begin
            dm_ack_d = 1'b1;
            if (!dm_we) dm_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      last_gnt_q <= GNT_IF_SEL;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign gnt    = (state_q == GNT_IF) || (state_q == GNT_DM);
  assign sel_dm = (state_q == GNT_DM);

  mux2 #(.W(ADDR_W)) u_addr_mux (
    .sel (sel_dm),
    .a   (if_addr),
    .b   (dm_addr),
    .y   (addr_mux)
  );

  // Fetch never writes; its data leg is tied to zero.
  mux2 #(.W(DATA_W)) u_wdata_mux (
    .sel (sel_dm),
    .a   ('0),
    .b   (dm_wdata),
    .y   (wdata_mux)
  );

  assign mem_en    = gnt;
  assign busy      = gnt;
  assign mem_we    = sel_dm && dm_we;
  assign mem_addr  = gnt ? addr_mux : '0;
  assign mem_wdata = gnt ? wdata_mux : '0;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: WAIT_CYCLES=2 and WAIT_CYCLES=0.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_en, mem_we, busy;

  logic [31:0] if_rdata0, dm_rdata0, mem_addr0, mem_wdata0;
  logic        if_ack0, dm_ack0, mem_en0, mem_we0, busy0;

  int n_cmp = 0;
  int n_bad = 0;

  logic        e_en, e_ack, e_dm;
  logic [31:0] e_w;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata0), .if_ack(if_ack0),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata0), .dm_ack(dm_ack0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata), .busy(busy0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
    if_addr = 32'h1234; dm_addr = 32'h5678; dm_wdata = 32'h9abc;
    mem_rdata = 32'hffff_ffff;
    tick;
    tick;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_we, busy, if_ack, dm_ack} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 00000",
               {mem_en, mem_we, busy, if_ack, dm_ack});
    end
    n_cmp++;
    if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rdata got %h/%h want 0/0", if_rdata, dm_rdata);
    end
    n_cmp++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mem got %h/%h want 0/0", mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({mem_en0, busy0, if_ack0, dm_ack0} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_w0 got %b want 0000",
               {mem_en0, busy0, if_ack0, dm_ack0});
    end
    tick;
  endtask

  task automatic test_if_read;
    do_reset;
    if_req = 1'b1; if_addr = 32'h0040_0000; mem_rdata = 32'h2008_0005;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      e_en = (k >= 1 && k <= 3);
      n_cmp++;
      if (mem_en !== e_en || busy !== e_en || mem_we !== 1'b0) begin
        n_bad++;
        $display("FAIL if_read_en k=%0d got en%b busy%b we%b want en%b we0",
                 k, mem_en, busy, mem_we, e_en);
      end
      e_ack = (k == 4);
      n_cmp++;
      if (if_ack !== e_ack || dm_ack !== 1'b0) begin
        n_bad++;
        $display("FAIL if_read_ack k=%0d got %b/%b want %b/0",
                 k, if_ack, dm_ack, e_ack);
      end
      if (k == 1) begin
        n_cmp++;
        if (mem_addr !== 32'h0040_0000) begin
          n_bad++;
          $display("FAIL if_read_addr got %h want 00400000", mem_addr);
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (if_rdata !== 32'h2008_0005) begin
          n_bad++;
          $display("FAIL if_read_rdata got %h want 20080005", if_rdata);
        end
      end
      if (k == 4) if_req = 1'b0;
      tick;
    end
  endtask

  task automatic test_both;
    do_reset;
    if_addr = 32'h0040_0010; dm_addr = 32'h1000_0040; dm_we = 1'b0;
    mem_rdata = 32'ha5a5_0001;
    if_req = 1'b1; dm_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      e_en = (k >= 1 && k <= 3) || (k >= 5 && k <= 7);
      n_cmp++;
      if (mem_en !== e_en) begin
        n_bad++;
        $display("FAIL both_en k=%0d got %b want %b", k, mem_en, e_en);
      end
      n_cmp++;
      if (dm_ack !== (k == 4) || if_ack !== (k == 8)) begin
        n_bad++;
        $display("FAIL both_ack k=%0d got dm%b if%b want dm%b if%b",
                 k, dm_ack, if_ack, k == 4, k == 8);
      end
      if (k == 1 || k == 5) begin
        e_w = (k == 1) ? 32'h1000_0040 : 32'h0040_0010;
        n_cmp++;
        if (mem_addr !== e_w) begin
          n_bad++;
          $display("FAIL both_addr k=%0d got %h want %h", k, mem_addr, e_w);
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (dm_rdata !== 32'ha5a5_0001) begin
          n_bad++;
          $display("FAIL both_dm_rdata got %h want a5a50001", dm_rdata);
        end
      end
      if (k == 9) begin
        n_cmp++;
        if (if_rdata !== 32'h5a5a_0002) begin
          n_bad++;
          $display("FAIL both_if_rdata got %h want 5a5a0002", if_rdata);
        end
      end
      if (k == 4) begin
        dm_req = 1'b0;
        mem_rdata = 32'h5a5a_0002;
      end
      if (k == 8) if_req = 1'b0;
      tick;
    end
  endtask

  task automatic test_store;
    dm_we = 1'b1; dm_addr = 32'h1001_0000; dm_wdata = 32'hdead_beef;
    mem_rdata = 32'h1111_1111;
    dm_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      e_en = (k >= 1 && k <= 3);
      e_w = e_en ? 32'hdead_beef : 32'h0;
      n_cmp++;
      if (mem_en !== e_en || mem_we !== e_en) begin
        n_bad++;
        $display("FAIL store_en k=%0d got en%b we%b want %b", k, mem_en, mem_we, e_en);
      end
      n_cmp++;
      if (mem_wdata !== e_w) begin
        n_bad++;
        $display("FAIL store_wdata k=%0d got %h want %h", k, mem_wdata, e_w);
      end
      n_cmp++;
      if (dm_ack !== (k == 4)) begin
        n_bad++;
        $display("FAIL store_ack k=%0d got %b want %b", k, dm_ack, k == 4);
      end
      if (k == 2) begin
        n_cmp++;
        if (mem_addr !== 32'h1001_0000) begin
          n_bad++;
          $display("FAIL store_addr got %h want 10010000", mem_addr);
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (dm_rdata !== 32'ha5a5_0001) begin
          n_bad++;
          $display("FAIL store_rdata got %h want a5a50001", dm_rdata);
        end
      end
      if (k == 4) dm_req = 1'b0;
      tick;
    end
    dm_we = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset;
    if_addr = 32'h0040_0100; dm_addr = 32'h1000_0200;
    if_req = 1'b1; dm_req = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      e_en = (k >= 1) && (k % 4 != 0);
      e_dm = (((k - 1) / 4) % 2) == 0;
      n_cmp++;
      if (mem_en !== e_en) begin
        n_bad++;
        $display("FAIL b2b_en k=%0d got %b want %b", k, mem_en, e_en);
      end
      if (e_en) begin
        e_w = e_dm ? 32'h1000_0200 : 32'h0040_0100;
        n_cmp++;
        if (mem_addr !== e_w) begin
          n_bad++;
          $display("FAIL b2b_addr k=%0d got %h want %h", k, mem_addr, e_w);
        end
      end
      n_cmp++;
      if (dm_ack !== (k == 4 || k == 12) || if_ack !== (k == 8 || k == 16)) begin
        n_bad++;
        $display("FAIL b2b_ack k=%0d got dm%b if%b", k, dm_ack, if_ack);
      end
      if (k == 16) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    if_addr = 32'h0040_0300; dm_addr = 32'h1000_0300;
    if_req = 1'b1; dm_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2 || k == 4) begin
        n_cmp++;
        if (busy !== 1'b1 || mem_addr !== 32'h1000_0300) begin
          n_bad++;
          $display("FAIL rstmid_gnt k=%0d got busy%b addr %h want 1 10000300",
                   k, busy, mem_addr);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (mem_en !== 1'b0 || busy !== 1'b0) begin
          n_bad++;
          $display("FAIL rstmid_abort got en%b busy%b want 0 0", mem_en, busy);
        end
      end
      n_cmp++;
      if (dm_ack !== (k == 7) || if_ack !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid_ack k=%0d got dm%b if%b want dm%b if0",
                 k, dm_ack, if_ack, k == 7);
      end
      if (k == 2) rst_n = 1'b0;
      if (k == 3) rst_n = 1'b1;
      if (k == 7) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      tick;
    end
  endtask

  task automatic test_wait0_and_drop;
    do_reset;
    if_addr = 32'h0040_0abc; mem_rdata = 32'h0bad_f00d;
    if_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_en0 !== (k == 1)) begin
        n_bad++;
        $display("FAIL w0_en k=%0d got %b want %b", k, mem_en0, k == 1);
      end
      n_cmp++;
      if (if_ack0 !== (k == 2)) begin
        n_bad++;
        $display("FAIL w0_ack k=%0d got %b want %b", k, if_ack0, k == 2);
      end
      if (k == 1) begin
        n_cmp++;
        if (mem_addr0 !== 32'h0040_0abc) begin
          n_bad++;
          $display("FAIL w0_addr got %h want 00400abc", mem_addr0);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (if_rdata0 !== 32'h0bad_f00d) begin
          n_bad++;
          $display("FAIL w0_rdata got %h want 0badf00d", if_rdata0);
        end
      end
      n_cmp++;
      if (if_ack !== (k == 4)) begin
        n_bad++;
        $display("FAIL drop_ack k=%0d got %b want %b", k, if_ack, k == 4);
      end
      if (k == 2) if_req = 1'b0;
      tick;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    test_reset;
    test_if_read;
    test_both;
    test_store;
    test_back_to_back;
    test_reset_mid;
    test_wait0_and_drop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
